// File: rtl/peripheral_crc_7_check_pkg.sv
// Shared definitions for the CRC7 frame checker: register map, polynomial,
// FSM state encoding, STATUS bit positions and the single-bit CRC7 step.
package crc7_chk_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CALC   = 4'h6;
    localparam logic [3:0] ADDR_RXCRC  = 4'h8;
    localparam logic [3:0] ADDR_ERRCNT = 4'hA;

    // x^7 + x^3 + 1 with the x^7 term implied
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } crc7_state_e;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_CRC_OK  = 2;
    localparam int STAT_END_OK  = 3;
    localparam int STAT_OVERRUN = 4;

    // One MSB-first LFSR step of CRC7 for input bit b
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/peripheral_crc_7_check_core.sv
// Bit-serial CRC7 engine: an 8-bit shift register feeds the LFSR one bit per
// cycle, MSB first. load_i starts an 8-cycle run, done_o marks its last cycle,
// clear_i zeroes the CRC and aborts any run in progress (clear beats load).
module crc7_serial_core
    import crc7_chk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       clear_i,
    input  logic [7:0] byte_i,
    output logic       done_o,
    output logic [6:0] crc_o
);

    logic [7:0] sr_q,     sr_d;
    logic [2:0] bit_q,    bit_d;
    logic       active_q, active_d;
    logic [6:0] crc_q,    crc_d;

    // Next-state for the shifter: clear, load a new byte, or shift one bit
    always_comb begin
        sr_d     = sr_q;
        bit_d    = bit_q;
        active_d = active_q;
        crc_d    = crc_q;
        if (clear_i) begin
            sr_d     = 8'h00;
            bit_d    = 3'd0;
            active_d = 1'b0;
            crc_d    = 7'h00;
        end else if (load_i) begin
            sr_d     = byte_i;
            bit_d    = 3'd0;
            active_d = 1'b1;
        end else if (active_q) begin
            crc_d = crc7_step(crc_q, sr_q[7]);
            sr_d  = {sr_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
                active_d = 1'b0;
            end
        end
    end

    // Shifter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q     <= 8'h00;
            bit_q    <= 3'd0;
            active_q <= 1'b0;
            crc_q    <= 7'h00;
        end else begin
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            crc_q    <= crc_d;
        end
    end

    assign done_o = active_q && (bit_q == 3'd7);
    assign crc_o  = crc_q;

endmodule

// File: rtl/peripheral_crc_7_check.sv
// Memory-mapped CRC7 frame checker (receive side of the SD command CRC).
// Software writes frame bytes to DATA; the payload is folded into the CRC
// bit-serially and the final byte is compared as {crc[6:0], end_bit}.
// Optional feature: define CRC7_CHK_ERRCNT_EN to add a saturating 8-bit
// error counter at ERRCNT (cleared only by rst); otherwise ERRCNT reads 0.
module peripheral_crc_7_check
    import crc7_chk_pkg::*;
#(
    parameter int FRAME_BYTES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    crc7_state_e state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [6:0]  rxcrc_q, rxcrc_d;
    logic        end_q, end_d;
    logic        crc_ok_q, crc_ok_d;
    logic        end_ok_q, end_ok_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic [15:0] d_out_q, d_out_d;

    logic        data_wr;
    logic        ctrl_clr;
    logic        busy;
    logic        core_load;
    logic        core_done;
    logic [6:0]  crc;
    logic        crc_match;
    logic [7:0]  errcnt_rd;
    logic [4:0]  status_w;
    logic        unused_d_in;

    assign data_wr     = cs && wr && (addr == ADDR_DATA);
    assign ctrl_clr    = cs && wr && (addr == ADDR_CTRL) && d_in[0];
    assign busy        = (state_q == SHIFT) || (state_q == CHECK);
    assign crc_match   = (crc == rxcrc_q);
    assign unused_d_in = ^d_in[15:8];

    crc7_serial_core u_core (
        .clk     (clk),
        .rst     (rst),
        .load_i  (core_load),
        .clear_i (ctrl_clr),
        .byte_i  (d_in[7:0]),
        .done_o  (core_done),
        .crc_o   (crc)
    );

    // Frame FSM next-state and result/status updates; a CTRL clear overrides all
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rxcrc_d   = rxcrc_q;
        end_d     = end_q;
        crc_ok_d  = crc_ok_q;
        end_ok_d  = end_ok_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        core_load = 1'b0;
        if (ctrl_clr) begin
            state_d   = IDLE;
            count_d   = 4'd0;
            rxcrc_d   = 7'h00;
            end_d     = 1'b0;
            crc_ok_d  = 1'b0;
            end_ok_d  = 1'b0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_wr) begin
                        if (count_q < LAST_IDX) begin
                            core_load = 1'b1;
                            count_d   = count_q + 4'd1;
                            state_d   = SHIFT;
                        end else begin
                            rxcrc_d = d_in[7:1];
                            end_d   = d_in[0];
                            state_d = CHECK;
                        end
                    end
                end
                SHIFT: begin
                    if (data_wr) overrun_d = 1'b1;
                    if (core_done) state_d = IDLE;
                end
                CHECK: begin
                    if (data_wr) overrun_d = 1'b1;
                    crc_ok_d = crc_match;
                    end_ok_d = end_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
                DONE: begin
                    if (data_wr) overrun_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, frame bookkeeping and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            rxcrc_q   <= 7'h00;
            end_q     <= 1'b0;
            crc_ok_q  <= 1'b0;
            end_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rxcrc_q   <= rxcrc_d;
            end_q     <= end_d;
            crc_ok_q  <= crc_ok_d;
            end_ok_q  <= end_ok_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef CRC7_CHK_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Count failed checks (bad CRC or bad end bit), saturating; an aborted CHECK is not counted
    always_comb begin
        errcnt_d = errcnt_q;
        if ((state_q == CHECK) && !ctrl_clr && !(crc_match && end_q) && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) errcnt_q <= 8'h00;
        else      errcnt_q <= errcnt_d;
    end

    assign errcnt_rd = errcnt_q;
`else
    assign errcnt_rd = 8'h00;
`endif

    // Read mux over the pre-write register values; d_out holds when not read
    always_comb begin
        status_w               = 5'b0;
        status_w[STAT_BUSY]    = busy;
        status_w[STAT_DONE]    = done_q;
        status_w[STAT_CRC_OK]  = crc_ok_q;
        status_w[STAT_END_OK]  = end_ok_q;
        status_w[STAT_OVERRUN] = overrun_q;
        d_out_d = d_out_q;
        if (cs && rd) begin
            case (addr)
                ADDR_STATUS: d_out_d = {11'b0, status_w};
                ADDR_CALC:   d_out_d = {4'b0, count_q, 1'b0, crc};
                ADDR_RXCRC:  d_out_d = {7'b0, end_q, 1'b0, rxcrc_q};
                ADDR_ERRCNT: d_out_d = {8'b0, errcnt_rd};
                default:     d_out_d = 16'h0000;
            endcase
        end
    end

    // Registered read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_out_q <= 16'h0000;
        else      d_out_q <= d_out_d;
    end

    assign d_out = d_out_q;

endmodule

// File: doc/peripheral_crc_7_check.md
# peripheral_crc_7_check

Memory-mapped CRC7 checker for the SPI_SD subsystem: software pushes the bytes of a received SD frame one at a time, and the block verifies them. Each frame is a 6-byte command/response, either 5 payload bytes plus a CRC/end-bit byte, or a longer frame set by parameter. The block computes the CRC7 (x^7+x^3+1, MSB first, init 0) bit-serially over the payload and compares it with the received CRC field. It also checks the end bit. It sits on the same peripheral bus as the CRC7 generator and is its receive-side counterpart.

## Interface
- FRAME_BYTES, 6, total frame length including the final CRC/end-bit byte (2..15)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- d_in  in  16  write data
- cs  in  1  chip select, active high
- addr  in  4  register address
- rd  in  1  read strobe, qualified by cs
- wr  in  1  write strobe, qualified by cs
- d_out  out  16  registered read data

## Operation
- Write registers:
  - 0x0 DATA: d_in[7:0] is a frame byte.
  - 0x2 CTRL: d_in[0]=1 clears the frame (crc=0, byte count=0, status cleared, state IDLE).
- Read registers:
  - 0x4 STATUS: bit0 busy, bit1 done, bit2 crc_ok, bit3 end_ok, bit4 overrun.
  - 0x6 CALC: [6:0] computed CRC, [11:8] byte count.
  - 0x8 RXCRC: [6:0] received CRC field, [8] received end bit.
  - 0xA ERRCNT: see Configuration.
  - Other addresses read 0.
- Per-bit CRC step: fb = crc[6]^b; crc = {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
- FSM states:
  - IDLE: a DATA write with count < FRAME_BYTES-1 loads the shift register, increments count and goes to SHIFT. A DATA write with count == FRAME_BYTES-1 latches rxcrc=byte[7:1] and end=byte[0], then goes to CHECK.
  - SHIFT: shifts one bit per cycle MSB first for 8 cycles, then returns to IDLE.
  - CHECK: one cycle. Sets crc_ok=(crc==rxcrc) and end_ok=end, then goes to DONE.
  - DONE: holds the results until a CTRL clear.
- busy is 1 in SHIFT and CHECK.
- A DATA write while busy or in DONE is ignored and sets overrun. overrun is sticky until CTRL clear.
- A CTRL clear in the same cycle as a DATA write, or during SHIFT/CHECK: the clear wins. The in-flight byte is discarded.
- rd and wr in the same cycle: d_out reflects the pre-write state.
- Reset: all registers, crc, count, status and d_out are 0. State is IDLE.

## Timing
- DATA write in cycle N: busy=1 from N+1 through N+8. The CRC is updated at the end of N+8, and a new byte is accepted from N+9.
- CRC byte written in cycle N: CHECK in N+1. done, crc_ok and end_ok are visible in STATUS from N+2.
- Read: cs&rd&addr sampled in cycle N gives d_out valid after the edge, in N+1. d_out holds its value when no read occurs.
- Reset asserted mid-SHIFT: the block immediately enters the reset state. No partial result is retained.

## Configuration
- Macro CRC7_CHK_ERRCNT_EN.
- Defined: an 8-bit error counter increments in CHECK when !(crc_ok && end_ok). It saturates at 0xFF, is cleared only by rst (not by CTRL clear), and is readable at 0xA [7:0].
- Not defined: there is no counter and 0xA reads 0.

## Structure
- Package crc7_chk_pkg contains:
  - Register address constants ADDR_DATA/CTRL/STATUS/CALC/RXCRC/ERRCNT.
  - CRC7_POLY = 7'h09.
  - The FSM state enum (IDLE, SHIFT, CHECK, DONE).
  - STATUS bit index constants.
- One sub-module, crc7_serial_core, holds the 8-bit shift register, 3-bit bit counter and 7-bit LFSR. It has load, clear and done handshake signals. The top level owns the bus decode, FSM, status and counter.

## Test plan
- CMD0 frame 40 00 00 00 00 95 -> CALC=0x4A, STATUS done=1, crc_ok=1, end_ok=1, overrun=0.
- CMD8 frame 48 00 00 01 AA 87 -> CALC=0x43, crc_ok=1. CMD17 frame 51 00 00 00 00 55 -> CALC=0x2A, crc_ok=1.
- CMD0 payload with CRC byte 0x94 -> crc_ok=1, end_ok=0. With CRC byte 0x97 -> crc_ok=0. With CRC7_CHK_ERRCNT_EN defined, ERRCNT=2 after both frames.
- DATA written 3 cycles after a previous DATA write -> byte ignored, overrun=1, CALC unchanged. A further write in DONE also sets overrun. A CTRL clear returns STATUS=0 and CALC=0.
- CTRL clear written mid-SHIFT together with reset pulses -> busy=0 next cycle, count=0. Asynchronous rst low mid-frame -> d_out=0 and all status 0 without waiting for a clock edge.
